// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S / left-justified stereo serializer.
// Saturating mix support is used only when I2S_MIX_EN is defined.
package i2s_pkg;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_LJ  = 1'b1;

  localparam int DEF_BCLK_HALF = 8;
  localparam int DEF_SLOT_BITS = 32;
  localparam int SAT_MAXW      = 32;

  function automatic int frame_clks(input int half, input int slot);
    return 4 * half * slot;
  endfunction

  localparam int FRAME_CLKS = frame_clks(DEF_BCLK_HALF, DEF_SLOT_BITS);

  // Operands arrive sign-extended to SAT_MAXW; result clamps to w-bit range.
  function automatic logic [SAT_MAXW-1:0] sat_add(
    input logic [SAT_MAXW-1:0] a,
    input logic [SAT_MAXW-1:0] b,
    input int                  w
  );
    logic signed [SAT_MAXW:0] s;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    s  = $signed({a[SAT_MAXW-1], a}) + $signed({b[SAT_MAXW-1], b});
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s[SAT_MAXW-1:0];
  endfunction

endpackage

// File: rtl/i2s_stereo_tx_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF clk cycles and
// flags the cycle in which bclk goes from 1 to 0.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall
);

  localparam int DW = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DW-1:0] TC = DW'(BCLK_HALF - 1);

  logic [DW-1:0] div;
  logic          tc;

  assign tc   = (div == TC);
  assign fall = tc & bclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (tc) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left-justified serializer with per-frame sample latch.
// Define I2S_MIX_EN to add the aux_l/aux_r saturating mix inputs.
module i2s_stereo_tx
  import i2s_pkg::*;
#(
  parameter int CLKMHZ    = 50,
  parameter int BCLK_HALF = DEF_BCLK_HALF,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int WIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fmt_lj,
  input  logic             mute,
  input  logic [WIDTH-1:0] audio_l,
  input  logic [WIDTH-1:0] audio_r,
`ifdef I2S_MIX_EN
  input  logic [WIDTH-1:0] aux_l,
  input  logic [WIDTH-1:0] aux_r,
`endif
  output logic             sample_strobe,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             i2s_dout
);

  localparam int FRAME = frame_clks(BCLK_HALF, SLOT_BITS);
  localparam int BW    = $clog2(2 * SLOT_BITS);
  localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT   = BW'(SLOT_BITS);

  if (BCLK_HALF < 2 || WIDTH < 2 || WIDTH > SLOT_BITS - 1 ||
      CLKMHZ < 1 || FRAME < 16) begin : g_bad_cfg
    $error("i2s_stereo_tx: illegal parameter set");
  end

  function automatic logic ser_bit(
    input logic             lj,
    input logic [BW-1:0]    p,
    input logic [WIDTH-1:0] s
  );
    logic [WIDTH-1:0] t;
    int               i;
    i = int'(p);
    t = '0;
    if (lj == FMT_LJ) begin
      if (i < WIDTH) t = s << i;
    end else if (i >= 1 && i <= WIDTH) begin
      t = s << (i - 1);
    end
    return t[WIDTH-1];
  endfunction

  logic             fall;
  logic             run;
  logic             fmt_q;
  logic             start;
  logic             fmt_nx;
  logic             lr_nx;
  logic             dout_nx;
  logic [BW-1:0]    b;
  logic [BW-1:0]    b_nx;
  logic [BW-1:0]    p_nx;
  logic [WIDTH-1:0] sh_l;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] src_l;
  logic [WIDTH-1:0] src_r;
  logic [WIDTH-1:0] sl_nx;
  logic [WIDTH-1:0] sr_nx;

  i2s_bclk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_bclk (
    .clk  (clk),
    .reset(reset),
    .bclk (i2s_bclk),
    .fall (fall)
  );

`ifdef I2S_MIX_EN
  assign src_l = WIDTH'(sat_add(SAT_MAXW'(signed'(audio_l)),
                                SAT_MAXW'(signed'(aux_l)), WIDTH));
  assign src_r = WIDTH'(sat_add(SAT_MAXW'(signed'(audio_r)),
                                SAT_MAXW'(signed'(aux_r)), WIDTH));
`else
  assign src_l = audio_l;
  assign src_r = audio_r;
`endif

  // Next-state view of the frame; dout is derived from the values
  // that become current on the same fall event.
  always_comb begin
    start  = !run || (b == B_LAST);
    b_nx   = start ? '0 : b + BW'(1);
    lr_nx  = (b_nx >= SLOT);
    p_nx   = lr_nx ? b_nx - SLOT : b_nx;
    fmt_nx = start ? fmt_lj : fmt_q;
    sl_nx  = sh_l;
    sr_nx  = sh_r;
    if (start) begin
      sl_nx = mute ? '0 : src_l;
      sr_nx = mute ? '0 : src_r;
    end
    dout_nx = ser_bit(fmt_nx, p_nx, lr_nx ? sr_nx : sl_nx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run           <= 1'b0;
      b             <= '0;
      i2s_lrclk     <= 1'b0;
      i2s_dout      <= 1'b0;
      sh_l          <= '0;
      sh_r          <= '0;
      fmt_q         <= FMT_I2S;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (fall) begin
        run           <= 1'b1;
        b             <= b_nx;
        i2s_lrclk     <= lr_nx;
        i2s_dout      <= dout_nx;
        sh_l          <= sl_nx;
        sh_r          <= sr_nx;
        fmt_q         <= fmt_nx;
        sample_strobe <= start;
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx at default parameters.
// Frame vectors are indexed by frame bit b (bit 0 = first bit after strobe).
module tb_i2s_stereo_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        fmt_lj;
  logic        mute;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
`ifdef I2S_MIX_EN
  logic [15:0] aux_l;
  logic [15:0] aux_r;
`endif
  logic        sample_strobe;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_dout;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  int nstr = 0;
  int gap  = 0;

  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  i2s_stereo_tx dut (
    .clk          (clk),
    .reset        (reset),
    .fmt_lj       (fmt_lj),
    .mute         (mute),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
`ifdef I2S_MIX_EN
    .aux_l        (aux_l),
    .aux_r        (aux_r),
`endif
    .sample_strobe(sample_strobe),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_dout     (i2s_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sample_strobe === 1'b1) nstr <= nstr + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_fall(output int n);
    logic prev;
    logic seen;
    prev = i2s_bclk;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen = prev && !i2s_bclk;
      prev = i2s_bclk;
    end
    if (!seen) chk("bclk_fall_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sample_strobe !== 1'b1 && n < 2100);
    if (sample_strobe !== 1'b1) chk("strobe_timeout", 64'(n), 64'd0);
  endtask

  task automatic read_bits(input int cnt, output logic [63:0] d,
                           output logic [63:0] l);
    int g;
    d = 64'(i2s_dout);
    l = 64'(i2s_lrclk);
    for (int k = 1; k < cnt; k++) begin
      next_fall(g);
      d = d | (64'(i2s_dout) << k);
      l = l | (64'(i2s_lrclk) << k);
    end
    gap = g;
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] l;
    int          n;
    int          ca;
    int          sa;

    reset   = 1'b1;
    fmt_lj  = 1'b0;
    mute    = 1'b0;
    audio_l = 16'h8001;
    audio_r = 16'h0000;
`ifdef I2S_MIX_EN
    aux_l = 16'h0000;
    aux_r = 16'h0000;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bclk", 64'(i2s_bclk), 64'd0);
    chk("rst_lrclk", 64'(i2s_lrclk), 64'd0);
    chk("rst_dout", 64'(i2s_dout), 64'd0);
    chk("rst_strobe", 64'(sample_strobe), 64'd0);
    reset = 1'b0;

    // I2S, left 8001: MSB at p1, LSB at p16
    wait_strobe(n);
    chk("first_strobe_latency", 64'(n), 64'd16);
    chk("first_lrclk", 64'(i2s_lrclk), 64'd0);
    read_bits(64, d, l);
    chk("i2s_8001_bits", d, 64'h0000_0000_0001_0002);
    chk("i2s_8001_lrclk", l, LR_EXP);
    chk("bit_period", 64'(gap), 64'd16);

    // LJ, right C000
    fmt_lj  = 1'b1;
    audio_l = 16'h0000;
    audio_r = 16'hC000;
    wait_strobe(n);
    read_bits(64, d, l);
    chk("lj_c000_bits", d, 64'h0000_0003_0000_0000);
    chk("lj_c000_lrclk", l, LR_EXP);

    // Strobe period and mid-frame input change
    audio_l = 16'hA5A5;
    audio_r = 16'h0000;
    wait_strobe(n);
    ca = cyc;
    sa = nstr;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 audio_l = 16'h1234;
      end
    join_none
    read_bits(64, d, l);
    chk("lj_a5a5_hold", d, 64'h0000_0000_0000_A5A5);
    wait_strobe(n);
    chk("strobe_period", 64'(cyc - ca), 64'd1024);
    chk("strobe_count", 64'(nstr - sa), 64'd1);
    read_bits(64, d, l);
    chk("lj_1234_next", d, 64'h0000_0000_0000_2C48);

    mute    = 1'b1;
    audio_l = 16'hFFFF;
    audio_r = 16'hFFFF;
    wait_strobe(n);
    read_bits(64, d, l);
    chk("mute_bits", d, 64'd0);
    chk("mute_lrclk", l, LR_EXP);

    // Reset in the middle of the right slot
    mute    = 1'b0;
    audio_l = 16'h0000;
    wait_strobe(n);
    read_bits(41, d, l);
    chk("pre_rst_lrclk", 64'(i2s_lrclk), 64'd1);
    chk("pre_rst_dout", 64'(i2s_dout), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_bclk", 64'(i2s_bclk), 64'd0);
    chk("mid_rst_lrclk", 64'(i2s_lrclk), 64'd0);
    chk("mid_rst_dout", 64'(i2s_dout), 64'd0);
    chk("mid_rst_strobe", 64'(sample_strobe), 64'd0);
    repeat (2) @(posedge clk);
    audio_l = 16'h8000;
    audio_r = 16'h0000;
    #1 reset = 1'b0;
    wait_strobe(n);
    chk("post_rst_latency", 64'(n), 64'd16);
    chk("post_rst_lrclk", 64'(i2s_lrclk), 64'd0);
    read_bits(64, d, l);
    chk("post_rst_bits", d, 64'h0000_0000_0000_0001);
    chk("post_rst_lrclk_seq", l, LR_EXP);

    // Format change mid-frame takes effect at next frame
    fmt_lj = 1'b0;
    wait_strobe(n);
    fork
      begin
        repeat (100) @(posedge clk);
        #1 fmt_lj = 1'b1;
      end
    join_none
    read_bits(64, d, l);
    chk("fmt_old_i2s", d, 64'h0000_0000_0000_0002);
    wait_strobe(n);
    read_bits(64, d, l);
    chk("fmt_new_lj", d, 64'h0000_0000_0000_0001);

`ifdef I2S_MIX_EN
    audio_l = 16'h7000;
    aux_l   = 16'h2000;
    audio_r = 16'h9000;
    aux_r   = 16'hA000;
    wait_strobe(n);
    read_bits(64, d, l);
    chk("mix_sat_pos_neg", d, 64'h0000_0001_0000_FFFE);
    audio_l = 16'h0100;
    aux_l   = 16'hFF00;
    audio_r = 16'h1234;
    aux_r   = 16'h0000;
    wait_strobe(n);
    read_bits(64, d, l);
    chk("mix_zero_pass", d, 64'h0000_2C48_0000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
